// File: rtl/keyscan_pkg.sv
// Shared keypad constants and types for the key scanner and the calculator control FSM.
// Key bit index is row*NUM_COLS + col.
package keyscan_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef logic [NUM_KEYS-1:0] key_vec_t;
  typedef logic [NUM_ROWS-1:0] row_vec_t;
  typedef logic [NUM_COLS-1:0] col_vec_t;

  localparam int KEY_1   = 0;
  localparam int KEY_2   = 1;
  localparam int KEY_3   = 2;
  localparam int KEY_ADD = 3;
  localparam int KEY_4   = 4;
  localparam int KEY_5   = 5;
  localparam int KEY_6   = 6;
  localparam int KEY_SUB = 7;
  localparam int KEY_7   = 8;
  localparam int KEY_8   = 9;
  localparam int KEY_9   = 10;
  localparam int KEY_MUL = 11;
  localparam int KEY_0   = 12;
  localparam int KEY_CLR = 13;
  localparam int KEY_EQ  = 14;
  localparam int KEY_DIV = 15;

  // True when zero or one key is set.
  function automatic logic at_most_one(key_vec_t v);
    return (v & (v - key_vec_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// Keypad matrix lines plus the debounced key outputs seen by the control FSM.
interface key_matrix_scan_if;
  import keyscan_pkg::*;

  row_vec_t row;
  col_vec_t col;
  key_vec_t key_out;
  key_vec_t key_pulse;

  modport master (output row, output key_out, output key_pulse, input col);
  modport slave  (input row, input key_out, input key_pulse, output col);
endinterface

// File: rtl/keyscan_debounce.sv
// Whole-frame debounce: counts consecutive identical frames and commits stable ones.
// `KEYSCAN_MULTI_REJECT_EN blocks commit of frames with more than one key set.
module keyscan_debounce
  import keyscan_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     frame_end_i,
  input  key_vec_t frame_i,
  output key_vec_t key_out_o,
  output key_vec_t key_pulse_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_vec_t         prev_q, prev_d;
  key_vec_t         key_out_q, key_out_d;
  key_vec_t         key_pulse_q, key_pulse_d;
  logic             accept;

`ifdef KEYSCAN_MULTI_REJECT_EN
  // Multi-key frames are likely ghosts; an empty frame still clears key_out.
  assign accept = at_most_one(frame_i);
`else
  assign accept = 1'b1;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    key_out_d   = key_out_q;
    key_pulse_d = '0;
    if (frame_end_i) begin
      if (frame_i == prev_q)
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      else
        cnt_d = '0;
      prev_d = frame_i;
      if (cnt_d == CNT_MAX && frame_i != key_out_q && accept) begin
        key_out_d   = frame_i;
        key_pulse_d = frame_i & ~key_out_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prev_q      <= '0;
      key_out_q   <= '0;
      key_pulse_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      key_out_q   <= key_out_d;
      key_pulse_q <= key_pulse_d;
    end
  end

  assign key_out_o   = key_out_q;
  assign key_pulse_o = key_pulse_q;

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: row driver, column synchronizer and per-row sampling into a frame.
// Optional `KEYSCAN_MULTI_REJECT_EN suppresses commits of multi-key frames.
module key_matrix_scan
  import keyscan_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic               clk,
  input logic               rst_n,
  key_matrix_scan_if.master kif
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SCAN_DIV - 1);

  logic [1:0][NUM_COLS-1:0] col_sync_q;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [1:0]               idx_q, idx_d;
  row_vec_t                 row_q, row_d;
  key_vec_t                 raw_q, raw_d;
  logic                     slot_last;
  logic                     frame_end;

  assign slot_last = (slot_q == SLOT_MAX);
  assign frame_end = slot_last && (idx_q == 2'd3);

  // raw_d already holds the row-3 columns at frame end, so it is the complete frame.
  always_comb begin
    slot_d = slot_last ? '0 : slot_q + SLOT_W'(1);
    idx_d  = slot_last ? idx_q + 2'd1 : idx_q;
    row_d  = ~(row_vec_t'(1) << idx_d);
    raw_d  = raw_q;
    if (slot_last)
      raw_d[{idx_q, 2'b00} +: NUM_COLS] = ~col_sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_sync_q <= '0;
      slot_q     <= '0;
      idx_q      <= '0;
      row_q      <= 4'b1110;
      raw_q      <= '0;
    end else begin
      col_sync_q <= {col_sync_q[0], kif.col};
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      raw_q      <= raw_d;
    end
  end

  assign kif.row = row_q;

  keyscan_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_end_i (frame_end),
    .frame_i     (raw_d),
    .key_out_o   (kif.key_out),
    .key_pulse_o (kif.key_pulse)
  );

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: frame-aligned keypad model, directed table, corner sequences,
// and random frames checked against a frame-history debounce model.
module tb_key_matrix_scan;
  import keyscan_pkg::*;

  localparam int SD = 4;
  localparam int DS = 3;
  localparam int FRAME = 4 * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  colv;
  int tests = 0;
  int fails = 0;

  key_matrix_scan_if kif();
  assign kif.col = colv;

  key_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst_n(rst_n), .kif(kif)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    colv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.row[r] && keys[r*4+c]) colv[c] = 1'b0;
  end

  // Reference: the last DS sampled frames (seeded with the reset-state zero frame).
  logic [15:0] hist[$];
  logic [15:0] exp_out, exp_pulse;

  function automatic logic accepted(logic [15:0] f);
`ifdef KEYSCAN_MULTI_REJECT_EN
    return $countones(f) <= 1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    hist = {};
    hist.push_back(16'h0);
    exp_out = '0;
    exp_pulse = '0;
  endtask

  task automatic model_frame(input logic [15:0] f);
    logic stable;
    hist.push_back(f);
    if (hist.size() > DS) void'(hist.pop_front());
    stable = (hist.size() == DS);
    foreach (hist[i]) if (hist[i] != f) stable = 1'b0;
    exp_pulse = '0;
    if (stable && f != exp_out && accepted(f)) begin
      exp_pulse = f & ~exp_out;
      exp_out = f;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called on the negedge of slot 0 of row 0; returns on the negedge after frame end.
  task automatic run_frame(input logic [15:0] k);
    keys = k;
    for (int i = 0; i < FRAME; i++) begin
      chk("row", {12'h0, kif.row}, {12'h0, ~(4'b0001 << (i / SD))});
      chk("key_out", kif.key_out, exp_out);
      chk("key_pulse", kif.key_pulse, (i == 0) ? exp_pulse : 16'h0);
      @(negedge clk);
    end
    model_frame(k);
  endtask

  typedef struct {
    logic [15:0] k;
    logic [15:0] out;
    logic [15:0] pulse;
  } vec_t;
  vec_t tbl[23];

  function automatic vec_t v(logic [15:0] k, logic [15:0] o, logic [15:0] p);
    vec_t r;
    r.k = k; r.out = o; r.pulse = p;
    return r;
  endfunction

  initial begin
    int npulse;
    logic [15:0] lastp, cur;

    // '+' press/release, '5' bounce, then '1'+'=' together.
    tbl[0]  = v(16'h0008, 16'h0000, 16'h0000);
    tbl[1]  = v(16'h0008, 16'h0000, 16'h0000);
    tbl[2]  = v(16'h0008, 16'h0008, 16'h0008);
    tbl[3]  = v(16'h0008, 16'h0008, 16'h0000);
    tbl[4]  = v(16'h0000, 16'h0008, 16'h0000);
    tbl[5]  = v(16'h0000, 16'h0008, 16'h0000);
    tbl[6]  = v(16'h0000, 16'h0000, 16'h0000);
    tbl[7]  = v(16'h0020, 16'h0000, 16'h0000);
    tbl[8]  = v(16'h0000, 16'h0000, 16'h0000);
    tbl[9]  = v(16'h0020, 16'h0000, 16'h0000);
    tbl[10] = v(16'h0000, 16'h0000, 16'h0000);
    tbl[11] = v(16'h0020, 16'h0000, 16'h0000);
    tbl[12] = v(16'h0020, 16'h0000, 16'h0000);
    tbl[13] = v(16'h0020, 16'h0020, 16'h0020);
    tbl[14] = v(16'h0000, 16'h0020, 16'h0000);
    tbl[15] = v(16'h0000, 16'h0020, 16'h0000);
    tbl[16] = v(16'h0000, 16'h0000, 16'h0000);
    tbl[17] = v(16'h4001, 16'h0000, 16'h0000);
    tbl[18] = v(16'h4001, 16'h0000, 16'h0000);
`ifdef KEYSCAN_MULTI_REJECT_EN
    tbl[19] = v(16'h4001, 16'h0000, 16'h0000);
`else
    tbl[19] = v(16'h4001, 16'h4001, 16'h4001);
`endif
    tbl[20] = v(16'h0000, tbl[19].out, 16'h0000);
    tbl[21] = v(16'h0000, tbl[19].out, 16'h0000);
    tbl[22] = v(16'h0000, 16'h0000, 16'h0000);

    // Reset held for 10 cycles.
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_row", {12'h0, kif.row}, 16'h000E);
      chk("rst_key_out", kif.key_out, 16'h0);
      chk("rst_key_pulse", kif.key_pulse, 16'h0);
    end
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_frame(tbl[i].k);
      chk($sformatf("tbl%0d_out", i), kif.key_out, tbl[i].out);
      chk($sformatf("tbl%0d_pulse", i), kif.key_pulse, tbl[i].pulse);
    end

    // Long hold of '=' gives exactly one pulse.
    npulse = 0;
    lastp = '0;
    for (int f = 0; f < 50; f++) begin
      run_frame(16'h4000);
      if (kif.key_pulse != 16'h0) begin
        npulse++;
        lastp = kif.key_pulse;
      end
    end
    chk("hold_npulse", 16'(npulse), 16'd1);
    chk("hold_pulse_val", lastp, 16'h4000);
    chk("hold_key_out", kif.key_out, 16'h4000);
    for (int f = 0; f < 3; f++) run_frame(16'h0);
    chk("hold_release", kif.key_out, 16'h0);

    // Reset mid-hold: outputs clear at once, held key re-pulses after debounce.
    for (int f = 0; f < 3; f++) run_frame(16'h0008);
    chk("pre_rst_out", kif.key_out, 16'h0008);
    for (int i = 0; i < 6; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", kif.key_out, 16'h0);
    chk("midrst_pulse", kif.key_pulse, 16'h0);
    chk("midrst_row", {12'h0, kif.row}, 16'h000E);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int f = 0; f < 3; f++) run_frame(16'h0008);
    chk("rerst_out", kif.key_out, 16'h0008);
    chk("rerst_pulse", kif.key_pulse, 16'h0008);

    // Random frames: hold, single key, empty, or two keys.
    cur = 16'h0008;
    for (int f = 0; f < 200; f++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: ;
        3: cur = 16'h0;
        4: cur = 16'h1 << $urandom_range(0, 15);
        default: cur = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      endcase
      run_frame(cur);
    end
    chk("rand_final_out", kif.key_out, exp_out);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
